// File: rtl/rf_wb_scheduler_pkg.sv
// Shared types for the writeback path: register index, data word and the
// per-requester writeback payload.
package rf_wb_scheduler_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_W     = $clog2(NUM_REGS);

    typedef logic [WORD_SIZE-1:0] data_t;
    typedef logic [REG_W-1:0]     reg_t;

    typedef struct packed {
        reg_t  rd;
        data_t wd;
    } wb_req_t;

    // One-hot mask of a register; x0 never appears so it cannot be tracked.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_t r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/rf_wb_scheduler_sva.sv
// Protocol checker for the writeback scheduler: grant is one-hot-or-zero and
// decode never issues to a register that still has an outstanding producer.
module rf_wb_scheduler_sva
    import rf_wb_scheduler_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input logic                i_clk,
    input logic                i_rstn,
    input logic [N_REQ-1:0]    i_ready,
    input logic                i_issue_en,
    input reg_t                i_issue_rd,
    input logic                i_flush,
    input logic                i_wen,
    input reg_t                i_wnum,
    input logic [NUM_REGS-1:0] i_sb
);

    a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rstn)
        $onehot0(i_ready));

    // A writeback retiring the same register at this edge frees it for reissue
    a_no_issue_to_busy: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (i_issue_en && (i_issue_rd != '0) && !i_flush && !(i_wen && (i_wnum == i_issue_rd)))
        |-> !i_sb[i_issue_rd]);

endmodule

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant to the first requester at or after
// the pointer; the pointer moves past the winner only when i_adv is asserted.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_s;
    logic          found_s;
    int unsigned   idx_s;

    // Cyclic priority search starting at the pointer
    always_comb begin
        o_gnt   = '0;
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int off = 0; off < N; off++) begin
            idx_s = (int'(ptr_q) + off) % N;
            if (!found_s && i_req[idx_s]) begin
                found_s      = 1'b1;
                win_s        = PW'(idx_s);
                o_gnt[idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer advance past the winner, wrapping at N
    always_comb begin
        ptr_d = ptr_q;
        if (i_adv && found_s) begin
            if (win_s == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write port scheduler: round-robin arbitration between the
// writeback units, a registered write stage, and the RAW busy scoreboard.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic  [N_REQ-1:0]       i_req_valid,
    output logic  [N_REQ-1:0]       o_req_ready,
    input  reg_t  [N_REQ-1:0]       i_req_rd,
    input  data_t [N_REQ-1:0]       i_req_wd,
    input  logic                    i_issue_en,
    input  reg_t                    i_issue_rd,
    input  reg_t                    i_rs1,
    input  reg_t                    i_rs2,
    output logic                    o_rs1_busy,
    output logic                    o_rs2_busy,
    input  logic                    i_flush,
    output logic                    o_Wen,
    output reg_t                    o_Wnum,
    output data_t                   o_Wd
);

    logic [N_REQ-1:0]    gnt_s;
    logic [N_REQ-1:0]    ready_s;
    logic                hs_s;
    wb_req_t             sel_s;

    logic                wen_q;
    logic                wen_d;
    reg_t                wnum_q;
    reg_t                wnum_d;
    data_t               wd_q;
    data_t               wd_d;

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    rr_arbiter #(
        .N      (N_REQ)
    ) u_arb (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_req  (i_req_valid),
        .i_adv  (hs_s),
        .o_gnt  (gnt_s)
    );

    // Grants only go to valid requesters, so any ready bit is a handshake
    assign ready_s     = gnt_s & {N_REQ{i_rstn}};
    assign hs_s        = |(ready_s & i_req_valid);
    assign o_req_ready = ready_s;

    // Payload mux for the granted requester
    always_comb begin
        sel_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_s[k]) begin
                sel_s.rd = i_req_rd[k];
                sel_s.wd = i_req_wd[k];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Write stage next state; x0 handshakes complete without a write
    always_comb begin
        wen_d  = hs_s && (sel_s.rd != '0);
        wnum_d = wnum_q;
        wd_d   = wd_q;
        if (wen_d) begin
            wnum_d = sel_s.rd;
            wd_d   = sel_s.wd;
        end else begin
            wnum_d = wnum_q;
            wd_d   = wd_q;
        end
    end

    // Registered register-file write port
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wen_q  <= 1'b0;
            wnum_q <= '0;
            wd_q   <= '0;
        end else begin
            wen_q  <= wen_d;
            wnum_q <= wnum_d;
            wd_q   <= wd_d;
        end
    end

    assign o_Wen  = wen_q;
    assign o_Wnum = wnum_q;
    assign o_Wd   = wd_q;

    // Scoreboard next state: clear on retire, then set on issue so a new producer wins
    always_comb begin
        sb_d = sb_q;
        if (i_flush) begin
            sb_d = '0;
        end else begin
            if (wen_q) begin
                sb_d = sb_d & ~reg_mask(wnum_q);
            end else begin
                sb_d = sb_d;
            end
            if (i_issue_en && (i_issue_rd != '0)) begin
                sb_d = sb_d | reg_mask(i_issue_rd);
            end else begin
                sb_d = sb_d;
            end
        end
        sb_d[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign o_rs1_busy = sb_q[i_rs1];
    assign o_rs2_busy = sb_q[i_rs2];

    rf_wb_scheduler_sva #(
        .N_REQ      (N_REQ)
    ) u_sva (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_ready    (ready_s),
        .i_issue_en (i_issue_en),
        .i_issue_rd (i_issue_rd),
        .i_flush    (i_flush),
        .i_wen      (wen_q),
        .i_wnum     (wnum_q),
        .i_sb       (sb_q)
    );

endmodule
